// File: rtl/issue_ctrl.sv
// Scoreboard issue controller between Decode and Execute: register-hazard and
// in-flight-window stalls, plus a front-end flush window after taken redirects.
module issue_ctrl #(
  parameter int unsigned MAX_INFLIGHT = 4,
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        dec_valid,
  input  logic [4:0]  dec_rs0,
  input  logic [4:0]  dec_rs1,
  input  logic [4:0]  dec_rdt,
  input  logic        dec_use_rs0,
  input  logic        dec_use_rs1,
  input  logic        dec_wr_rd,
  input  logic        wb_valid,
  input  logic [4:0]  wb_rdt,
  input  logic        br_taken,
  output logic        issue,
  output logic        stall,
  output logic        flush,
  output logic [3:0]  inflight,
  output logic [31:0] busy
);

  localparam int unsigned CNT_W  = 4;
  localparam int unsigned FCNT_W = 3;
  localparam int unsigned SB_W   = 32;
  localparam logic [CNT_W-1:0]  MAX_CNT   = CNT_W'(MAX_INFLIGHT);
  localparam logic [FCNT_W-1:0] FCNT_LOAD = FCNT_W'(FLUSH_CYCLES - 1);

  typedef enum logic {S_RUN, S_FLUSH} state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [FCNT_W-1:0] r_fcnt;
  logic [FCNT_W-1:0] w_fcnt_nxt;
  logic [SB_W-1:0]   r_busy;
  logic [SB_W-1:0]   w_busy_nxt;
  logic [CNT_W-1:0]  r_inflight;
  logic [CNT_W-1:0]  w_inflight_nxt;
  logic              w_run;
  logic              w_hz_rs0;
  logic              w_hz_rs1;
  logic              w_hz_waw;
  logic              w_full;
  logic              w_wb_dec;

  assign busy     = r_busy;
  assign inflight = r_inflight;

  // Hazard detection; a writeback in the same cycle bypasses (write-first regfile).
  always_comb begin
    w_run    = (r_state == S_RUN);
    w_hz_rs0 = dec_use_rs0 & r_busy[dec_rs0] & ~(wb_valid & (wb_rdt == dec_rs0));
    w_hz_rs1 = dec_use_rs1 & r_busy[dec_rs1] & ~(wb_valid & (wb_rdt == dec_rs1));
    w_hz_waw = dec_wr_rd & (dec_rdt != 5'd0) & r_busy[dec_rdt]
             & ~(wb_valid & (wb_rdt == dec_rdt));
    w_full   = (r_inflight == MAX_CNT) & ~wb_valid;
    issue    = rst_n & dec_valid & w_run & ~br_taken
             & ~w_hz_rs0 & ~w_hz_rs1 & ~w_hz_waw & ~w_full;
    stall    = rst_n & dec_valid & w_run & ~br_taken & ~issue;
    flush    = rst_n & (br_taken | ~w_run);
  end

  // Redirect FSM: a taken branch (re)loads the squash countdown.
  always_comb begin
    w_state_nxt = r_state;
    w_fcnt_nxt  = r_fcnt;
    case (r_state)
      S_RUN: begin
        if (br_taken) begin
          w_state_nxt = S_FLUSH;
          w_fcnt_nxt  = FCNT_LOAD;
        end
      end
      S_FLUSH: begin
        if (br_taken) begin
          w_fcnt_nxt = FCNT_LOAD;
        end else if (r_fcnt == '0) begin
          w_state_nxt = S_RUN;
        end else begin
          w_fcnt_nxt = r_fcnt - FCNT_W'(1);
        end
      end
    endcase
  end

  // Scoreboard and window counter; clear before set so a same-cycle reuse stays busy.
  always_comb begin
    w_busy_nxt = r_busy;
    if (wb_valid) begin
      w_busy_nxt[wb_rdt] = 1'b0;
    end
    if (issue & dec_wr_rd & (dec_rdt != 5'd0)) begin
      w_busy_nxt[dec_rdt] = 1'b1;
    end
    w_busy_nxt[0] = 1'b0;

    w_wb_dec       = wb_valid & (r_inflight != '0);
    w_inflight_nxt = r_inflight;
    if (issue & ~w_wb_dec) begin
      w_inflight_nxt = r_inflight + CNT_W'(1);
    end else if (~issue & w_wb_dec) begin
      w_inflight_nxt = r_inflight - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= S_RUN;
      r_fcnt     <= '0;
      r_busy     <= '0;
      r_inflight <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_fcnt     <= w_fcnt_nxt;
      r_busy     <= w_busy_nxt;
      r_inflight <= w_inflight_nxt;
    end
  end

endmodule

// File: tb/tb_issue_ctrl.sv
// Self-checking bench for issue_ctrl: directed scenarios plus random traffic
// against a cycle-level reference model of scoreboard, window and flush span.
module tb_issue_ctrl;

  localparam int MAX_INFLIGHT = 4;
  localparam int FLUSH_CYCLES = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        dec_valid = 1'b0;
  logic [4:0]  dec_rs0 = '0;
  logic [4:0]  dec_rs1 = '0;
  logic [4:0]  dec_rdt = '0;
  logic        dec_use_rs0 = 1'b0;
  logic        dec_use_rs1 = 1'b0;
  logic        dec_wr_rd = 1'b0;
  logic        wb_valid = 1'b0;
  logic [4:0]  wb_rdt = '0;
  logic        br_taken = 1'b0;
  logic        issue;
  logic        stall;
  logic        flush;
  logic [3:0]  inflight;
  logic [31:0] busy;

  issue_ctrl #(.MAX_INFLIGHT(MAX_INFLIGHT), .FLUSH_CYCLES(FLUSH_CYCLES)) dut (
    .clk(clk), .rst_n(rst_n), .dec_valid(dec_valid),
    .dec_rs0(dec_rs0), .dec_rs1(dec_rs1), .dec_rdt(dec_rdt),
    .dec_use_rs0(dec_use_rs0), .dec_use_rs1(dec_use_rs1), .dec_wr_rd(dec_wr_rd),
    .wb_valid(wb_valid), .wb_rdt(wb_rdt), .br_taken(br_taken),
    .issue(issue), .stall(stall), .flush(flush), .inflight(inflight), .busy(busy)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_errors = 0;
  int          cyc = 0;
  logic [31:0] m_busy = '0;
  int          m_infl = 0;
  int          m_fl_until = -1;
  logic [4:0]  q[$];
  logic        s_issue, s_stall, s_flush;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s cycle=%0d got=%h expected=%h", tag, cyc, got, exp);
    end
  endtask

  task automatic set_instr(input logic v, input logic [4:0] r0, input logic u0,
                           input logic [4:0] r1, input logic u1,
                           input logic w, input logic [4:0] rd);
    dec_valid = v; dec_rs0 = r0; dec_use_rs0 = u0;
    dec_rs1 = r1; dec_use_rs1 = u1; dec_wr_rd = w; dec_rdt = rd;
  endtask

  // One clock cycle: compare against the model, then advance model and DUT.
  task automatic step();
    logic run, hz, full, e_issue, e_stall, e_flush;
    #1;
    run  = (cyc > m_fl_until);
    hz   = (dec_use_rs0 && m_busy[dec_rs0] && !(wb_valid && wb_rdt == dec_rs0)) ||
           (dec_use_rs1 && m_busy[dec_rs1] && !(wb_valid && wb_rdt == dec_rs1)) ||
           (dec_wr_rd && dec_rdt != 5'd0 && m_busy[dec_rdt] && !(wb_valid && wb_rdt == dec_rdt));
    full = (m_infl == MAX_INFLIGHT) && !wb_valid;
    e_issue = rst_n && dec_valid && run && !br_taken && !hz && !full;
    e_stall = rst_n && dec_valid && run && !br_taken && !e_issue;
    e_flush = rst_n && (br_taken || !run);
    check("issue", 32'(issue), 32'(e_issue));
    check("stall", 32'(stall), 32'(e_stall));
    check("flush", 32'(flush), 32'(e_flush));
    check("inflight", 32'(inflight), 32'(m_infl));
    check("busy", busy, m_busy);
    s_issue = issue; s_stall = stall; s_flush = flush;
    if (!rst_n) begin
      m_busy = '0; m_infl = 0; m_fl_until = -1; q.delete();
    end else begin
      if (wb_valid) begin
        m_busy[wb_rdt] = 1'b0;
        for (int i = 0; i < q.size(); i++) begin
          if (q[i] == wb_rdt) begin q.delete(i); break; end
        end
      end
      m_infl = m_infl + (e_issue ? 1 : 0) - ((wb_valid && m_infl > 0) ? 1 : 0);
      if (e_issue) begin
        if (dec_wr_rd && dec_rdt != 5'd0) m_busy[dec_rdt] = 1'b1;
        q.push_back(dec_wr_rd ? dec_rdt : 5'd0);
      end
      if (br_taken) m_fl_until = cyc + FLUSH_CYCLES;
    end
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic drain();
    dec_valid = 1'b0; br_taken = 1'b0;
    while (q.size() > 0) begin
      wb_valid = 1'b1; wb_rdt = q[0];
      step();
    end
    wb_valid = 1'b0; wb_rdt = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout got=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    @(negedge clk);
    // Reset held with a valid instruction present
    rst_n = 1'b0;
    set_instr(1, 0, 0, 0, 0, 1, 5);
    step(); step();
    check("rst_issue", 32'(s_issue), 32'd0);
    check("rst_stall", 32'(s_stall), 32'd0);
    check("rst_flush", 32'(s_flush), 32'd0);
    check("rst_busy", busy, 32'd0);
    check("rst_infl", 32'(inflight), 32'd0);
    rst_n = 1'b1;

    // RAW: writer x5, then reader stalls until its writeback
    step();
    check("ind_issue", 32'(s_issue), 32'd1);
    set_instr(1, 5, 1, 0, 0, 0, 0);
    repeat (3) begin
      step();
      check("raw_stall", 32'(s_stall), 32'd1);
    end
    wb_valid = 1'b1; wb_rdt = 5'd5;
    step();
    wb_valid = 1'b0;
    check("raw_issue_wb", 32'(s_issue), 32'd1);
    check("raw_busy5", 32'(busy[5]), 32'd0);
    drain();

    // x0 never marked busy, never hazards
    set_instr(1, 0, 0, 0, 0, 1, 0); step();
    set_instr(1, 0, 1, 0, 1, 0, 0); step();
    check("x0_stall", 32'(s_stall), 32'd0);
    check("x0_busy", busy, 32'd0);
    check("x0_infl", 32'(inflight), 32'd2);
    drain();

    // Window full, then writeback frees a slot in the same cycle
    for (int r = 1; r <= 4; r++) begin
      set_instr(1, 0, 0, 0, 0, 1, 5'(r)); step();
      check("win_issue", 32'(s_issue), 32'd1);
    end
    set_instr(1, 0, 0, 0, 0, 1, 6); step();
    check("win_stall", 32'(s_stall), 32'd1);
    check("win_infl", 32'(inflight), 32'd4);
    wb_valid = 1'b1; wb_rdt = 5'd1; step(); wb_valid = 1'b0;
    check("win_issue5", 32'(s_issue), 32'd1);
    check("win_infl_hold", 32'(inflight), 32'd4);
    drain();

    // Single redirect: flush T..T+2, issue at T+3
    set_instr(1, 0, 0, 0, 0, 0, 0);
    br_taken = 1'b1; step(); br_taken = 1'b0;
    check("fl_t0", 32'({s_flush, s_issue}), 32'b10);
    step(); check("fl_t1", 32'({s_flush, s_issue}), 32'b10);
    step(); check("fl_t2", 32'({s_flush, s_issue}), 32'b10);
    step(); check("fl_t3", 32'({s_flush, s_issue}), 32'b01);
    drain();
    // Back-to-back redirect extends through T+3
    br_taken = 1'b1; step(); step(); br_taken = 1'b0;
    step(); check("fl2_t2", 32'(s_flush), 32'd1);
    step(); check("fl2_t3", 32'(s_flush), 32'd1);
    step(); check("fl2_t4", 32'(s_flush), 32'd0);

    // Same register cleared and set in one cycle ends busy
    set_instr(1, 0, 0, 0, 0, 1, 7); step();
    wb_valid = 1'b1; wb_rdt = 5'd7; step(); wb_valid = 1'b0;
    check("sim_issue", 32'(s_issue), 32'd1);
    check("sim_busy7", 32'(busy[7]), 32'd1);
    check("sim_infl", 32'(inflight), 32'd1);
    drain();

    // Spurious writeback with empty window does not underflow
    wb_valid = 1'b1; wb_rdt = 5'd9; step(); wb_valid = 1'b0;
    check("uflow_infl", 32'(inflight), 32'd0);

    // Random traffic with occasional resets and redirects
    for (int n = 0; n < 3000; n++) begin
      rst_n = ($urandom_range(0, 299) != 0);
      set_instr(($urandom_range(0, 9) < 8), 5'($urandom_range(0, 7)), 1'($urandom),
                5'($urandom_range(0, 7)), 1'($urandom), 1'($urandom), 5'($urandom_range(0, 7)));
      wb_valid = 1'b0; wb_rdt = '0;
      if (q.size() > 0 && $urandom_range(0, 2) == 0) begin
        wb_valid = 1'b1;
        wb_rdt = q[$urandom_range(0, q.size() - 1)];
      end
      br_taken = ($urandom_range(0, 14) == 0);
      step();
    end
    rst_n = 1'b1;
    drain();
    step();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/issue_ctrl.md
# issue_ctrl

Scoreboard-based issue controller between the Decode stage and Execute. Each cycle it decides whether the decoded instruction may issue, holds Fetch/Decode on register hazards or a full in-flight window, and flushes the front end after a taken branch or jump. It tracks pending destination writes per architectural register and releases them on writeback.

## Interface
- MAX_INFLIGHT, 4: maximum issued-but-not-written-back instructions (2..15)
- FLUSH_CYCLES, 2: cycles the front end is squashed after a redirect (1..7)
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous, active-low reset
- dec_valid  in  1  Decode holds a valid instruction
- dec_rs0, dec_rs1  in  5  source register addresses
- dec_rdt  in  5  destination register address
- dec_use_rs0, dec_use_rs1  in  1  instruction reads rs0 / rs1 (R/I/S/B types per decode type bits)
- dec_wr_rd  in  1  instruction writes rdt (R/I/U/J types)
- wb_valid  in  1  a register write completes this cycle
- wb_rdt  in  5  register being written back
- br_taken  in  1  Execute resolved a taken branch/jump this cycle
- issue  out  1  instruction in Decode is accepted by Execute this cycle
- stall  out  1  hold Fetch PC and Decode register
- flush  out  1  squash Fetch/Decode contents
- inflight  out  4  current outstanding count
- busy  out  32  scoreboard, bit n = write to xn pending; bit 0 constant 0

## Operation
- State machine, two states: RUN, FLUSH. Down-counter fcnt (3 bits) used in FLUSH.
- RUN -> FLUSH on br_taken; fcnt loaded with FLUSH_CYCLES-1. FLUSH: fcnt decrements each cycle; FLUSH -> RUN when fcnt==0 and no br_taken. br_taken in FLUSH reloads fcnt, stays FLUSH.
- Source hazard: (dec_use_rs0 & busy[rs0] & !(wb_valid & wb_rdt==rs0)), same for rs1. Writeback this cycle bypasses the hazard (register file is write-first).
- WAW hazard: dec_wr_rd & rdt!=0 & busy[rdt] & !(wb_valid & wb_rdt==rdt).
- Window full: inflight==MAX_INFLIGHT and !wb_valid.
- issue = rst_n & dec_valid & state==RUN & !br_taken & !hazard & !full.
- stall = rst_n & dec_valid & state==RUN & !br_taken & !issue.
- flush = rst_n & (br_taken | state==FLUSH).
- Scoreboard update at edge: clear busy[wb_rdt] if wb_valid; then set busy[dec_rdt] if issue & dec_wr_rd & dec_rdt!=0. Same register cleared and set in one cycle -> ends set.
- inflight: +1 on issue, -1 on wb_valid, unchanged if both. wb_valid with inflight==0 is ignored (no underflow) and still clears busy bit. Instructions without a destination still count and must still return a wb_valid (wb_rdt=0).
- x0 never marked busy; reads of x0 never hazard.

## Timing
- Reset (rst_n low at an edge): state=RUN, fcnt=0, busy=0, inflight=0. While rst_n low: issue=0, stall=0, flush=0. Reset mid-FLUSH or with outstanding writes discards everything; no writebacks are expected afterwards.
- issue/stall/flush are combinational from registered state and current inputs, valid in the same cycle; scoreboard/inflight effects visible the following cycle.
- Redirect: br_taken at cycle T -> flush high cycles T..T+FLUSH_CYCLES; issue low over the same span; first possible issue at T+FLUSH_CYCLES+1.
- Back-to-back dependent instructions: consumer stalls until the producer's wb_valid cycle, issuing in that cycle.

## Test plan
- Reset: rst_n=0 for 2 cycles with dec_valid=1 -> issue=stall=flush=0, busy=0, inflight=0; release -> independent instr issues first cycle.
- RAW: issue writer rdt=5, next reads rs0=5 -> stall high until wb_valid wb_rdt=5 at cycle N; issue=1 at N, busy[5] clear at N+1.
- x0: writer rdt=0 then reader rs0=0 -> no stall, busy stays 0, inflight=2.
- Window full: MAX_INFLIGHT=4, 4 independent issues, no wb -> 5th stalls, inflight=4; wb_valid same cycle -> 5th issues, inflight stays 4.
- Flush: FLUSH_CYCLES=2, br_taken at T -> flush at T, T+1, T+2, issue 0; second br_taken at T+1 -> flush extends through T+3.
- Simultaneous set/clear: wb_rdt=7 and issuing writer rdt=7 same cycle -> busy[7]=1 next cycle, inflight unchanged.
